issue_queue_cdb: RTL and testbench

ISSUE_QUEUE_CDB -- requirements
Module: issue_queue_cdb

---
 rtl/issue_queue_cdb.sv | 147 ++++++++++++++
 tb/tb_issue_queue_cdb.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue_cdb.sv
// rtl/issue_queue_cdb.sv - oldest-first issue queue with CDB wakeup; optional same-cycle load bypass under IQ_CDB_BYPASS_EN
module issue_queue_cdb #(
  parameter int NUM_ENTRIES    = 8,
  parameter int REG_ADDR_WIDTH = 6,
  parameter int FUNC_WIDTH     = 4,
  parameter int NUM_CDB        = 2
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              flush,
  input  logic                              load,
  input  logic [FUNC_WIDTH-1:0]             insn,
  input  logic [REG_ADDR_WIDTH-1:0]         inp1,
  input  logic [REG_ADDR_WIDTH-1:0]         inp2,
  input  logic [REG_ADDR_WIDTH-1:0]         dst,
  input  logic                              inp1_ready,
  input  logic                              inp2_ready,
  input  logic [NUM_CDB-1:0]                cdb_valid,
  input  logic [NUM_CDB*REG_ADDR_WIDTH-1:0] cdb_tag,
  input  logic                              issue,
  output logic                              issue_ready,
  output logic                              is_full,
  output logic                              is_empty,
  output logic [$clog2(NUM_ENTRIES):0]      count,
  output logic [FUNC_WIDTH-1:0]             insn_out,
  output logic [REG_ADDR_WIDTH-1:0]         inp1_out,
  output logic [REG_ADDR_WIDTH-1:0]         inp2_out,
  output logic [REG_ADDR_WIDTH-1:0]         dst_out
);

  localparam int AW = $clog2(NUM_ENTRIES);
  localparam int CW = AW + 1;
  localparam int RW = REG_ADDR_WIDTH;

  logic [NUM_ENTRIES-1:0] valid_q;
  logic [NUM_ENTRIES-1:0] r1_q;
  logic [NUM_ENTRIES-1:0] r2_q;
  logic [FUNC_WIDTH-1:0]  insn_q [NUM_ENTRIES];
  logic [RW-1:0]          src1_q [NUM_ENTRIES];
  logic [RW-1:0]          src2_q [NUM_ENTRIES];
  logic [RW-1:0]          dst_q  [NUM_ENTRIES];
  // Age is the rank among valid entries: 0 is the oldest, ranks stay dense.
  logic [AW-1:0]          age_q  [NUM_ENTRIES];

  logic [CW-1:0] cnt;
  logic [AW-1:0] free_idx;
  logic          free_found;
  logic [AW-1:0] sel_idx;
  logic [AW-1:0] sel_age;
  logic          sel_found;
  logic          do_issue;
  logic          do_load;
  logic [AW-1:0] new_age;
  logic          ld_r1;
  logic          ld_r2;

  function automatic logic cdb_match(input logic [RW-1:0] tag,
                                     input logic [NUM_CDB-1:0] v,
                                     input logic [NUM_CDB*RW-1:0] tags);
    logic m;
    m = 1'b0;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (v[k] && (tags[k*RW +: RW] == tag)) m = 1'b1;
    end
    return m;
  endfunction

  always_comb begin
    cnt        = '0;
    free_idx   = '0;
    free_found = 1'b0;
    sel_idx    = '0;
    sel_age    = '1;
    sel_found  = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      cnt = cnt + CW'(valid_q[i]);
      if (!valid_q[i] && !free_found) begin
        free_idx   = AW'(i);
        free_found = 1'b1;
      end
      if (valid_q[i] && r1_q[i] && r2_q[i] && (!sel_found || age_q[i] < sel_age)) begin
        sel_idx   = AW'(i);
        sel_age   = age_q[i];
        sel_found = 1'b1;
      end
    end
  end

  assign count       = cnt;
  assign is_full     = (cnt == CW'(NUM_ENTRIES));
  assign is_empty    = (cnt == '0);
  assign issue_ready = sel_found;
  assign do_issue    = issue && sel_found;
  assign do_load     = load && !is_full;
  // Loads are refused while full, so cnt < NUM_ENTRIES here and fits in AW bits.
  assign new_age     = AW'(cnt - CW'(do_issue));

`ifdef IQ_CDB_BYPASS_EN
  assign ld_r1 = inp1_ready | cdb_match(inp1, cdb_valid, cdb_tag);
  assign ld_r2 = inp2_ready | cdb_match(inp2, cdb_valid, cdb_tag);
`else
  assign ld_r1 = inp1_ready;
  assign ld_r2 = inp2_ready;
`endif

  assign insn_out = sel_found ? insn_q[sel_idx] : '0;
  assign inp1_out = sel_found ? src1_q[sel_idx] : '0;
  assign inp2_out = sel_found ? src2_q[sel_idx] : '0;
  assign dst_out  = sel_found ? dst_q[sel_idx]  : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        insn_q[i] <= '0;
        src1_q[i] <= '0;
        src2_q[i] <= '0;
        dst_q[i]  <= '0;
        age_q[i]  <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (valid_q[i]) begin
          if (cdb_match(src1_q[i], cdb_valid, cdb_tag)) r1_q[i] <= 1'b1;
          if (cdb_match(src2_q[i], cdb_valid, cdb_tag)) r2_q[i] <= 1'b1;
          if (do_issue && (age_q[i] > sel_age)) age_q[i] <= age_q[i] - 1'b1;
        end
      end
      if (do_issue) valid_q[sel_idx] <= 1'b0;
      if (do_load) begin
        valid_q[free_idx] <= 1'b1;
        r1_q[free_idx]    <= ld_r1;
        r2_q[free_idx]    <= ld_r2;
        insn_q[free_idx]  <= insn;
        src1_q[free_idx]  <= inp1;
        src2_q[free_idx]  <= inp2;
        dst_q[free_idx]   <= dst;
        age_q[free_idx]   <= new_age;
      end
    end
  end

endmodule

// File: tb/tb_issue_queue_cdb.sv
// tb/tb_issue_queue_cdb.sv - bench for issue_queue_cdb against a dispatch-ordered list model
module tb_issue_queue_cdb;

  localparam int N = 8;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        load;
  logic [3:0]  insn;
  logic [5:0]  inp1;
  logic [5:0]  inp2;
  logic [5:0]  dst;
  logic        inp1_ready;
  logic        inp2_ready;
  logic [1:0]  cdb_valid;
  logic [11:0] cdb_tag;
  logic        issue;
  logic        issue_ready;
  logic        is_full;
  logic        is_empty;
  logic [3:0]  count;
  logic [3:0]  insn_out;
  logic [5:0]  inp1_out;
  logic [5:0]  inp2_out;
  logic [5:0]  dst_out;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0] insn;
    logic [5:0] s1;
    logic       r1;
    logic [5:0] s2;
    logic       r2;
    logic [5:0] d;
  } ent_t;

  // Entries kept in dispatch order: index 0 is the oldest.
  ent_t q[$];

  issue_queue_cdb dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .load(load),
    .insn(insn), .inp1(inp1), .inp2(inp2), .dst(dst),
    .inp1_ready(inp1_ready), .inp2_ready(inp2_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .issue(issue),
    .issue_ready(issue_ready), .is_full(is_full), .is_empty(is_empty),
    .count(count), .insn_out(insn_out), .inp1_out(inp1_out),
    .inp2_out(inp2_out), .dst_out(dst_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit hit(input logic [5:0] t);
    return (cdb_valid[0] && cdb_tag[5:0] == t) || (cdb_valid[1] && cdb_tag[11:6] == t);
  endfunction

  function automatic int oldest_ready();
    for (int i = 0; i < q.size(); i++) if (q[i].r1 && q[i].r2) return i;
    return -1;
  endfunction

  task automatic check_outputs();
    int s;
    ent_t e;
    s = oldest_ready();
    e = '0;
    if (s >= 0) e = q[s];
    chk("issue_ready", issue_ready, s >= 0);
    chk("count", count, q.size());
    chk("is_full", is_full, q.size() == N);
    chk("is_empty", is_empty, q.size() == 0);
    chk("insn_out", insn_out, e.insn);
    chk("inp1_out", inp1_out, e.s1);
    chk("inp2_out", inp2_out, e.s2);
    chk("dst_out", dst_out, e.d);
  endtask

  task automatic model_edge();
    int s;
    bit full;
    ent_t e;
    if (flush) begin
      q.delete();
      return;
    end
    s = oldest_ready();
    full = (q.size() == N);
    for (int i = 0; i < q.size(); i++) begin
      if (hit(q[i].s1)) q[i].r1 = 1'b1;
      if (hit(q[i].s2)) q[i].r2 = 1'b1;
    end
    if (issue && s >= 0) q.delete(s);
    if (load && !full) begin
      e = '{insn: insn, s1: inp1, r1: inp1_ready, s2: inp2, r2: inp2_ready, d: dst};
`ifdef IQ_CDB_BYPASS_EN
      if (hit(inp1)) e.r1 = 1'b1;
      if (hit(inp2)) e.r2 = 1'b1;
`endif
      q.push_back(e);
    end
  endtask

  task automatic tick();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
    load = 1'b0; issue = 1'b0; flush = 1'b0; cdb_valid = 2'b00;
  endtask

  task automatic put(input logic [3:0] i, input logic [5:0] a, input logic ra,
                     input logic [5:0] b, input logic rb, input logic [5:0] d);
    load = 1'b1; insn = i; inp1 = a; inp1_ready = ra; inp2 = b; inp2_ready = rb; dst = d;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; load = 1'b0; issue = 1'b0;
    insn = '0; inp1 = '0; inp2 = '0; dst = '0; inp1_ready = 1'b0; inp2_ready = 1'b0;
    cdb_valid = '0; cdb_tag = '0;
    #12;
    check_outputs();
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Fill with ready entries, then a ninth load must be dropped.
    for (int i = 0; i < N; i++) begin put(4'(i), 6'd1, 1'b1, 6'd2, 1'b1, 6'(i)); tick(); end
    chk("full_count", count, 8);
    chk("full_flag", is_full, 1);
    put(4'hf, 6'd1, 1'b1, 6'd2, 1'b1, 6'd63); tick();
    chk("ninth_ignored", count, 8);
    flush = 1'b1; tick();

    // A waits on tag 3; B and C issue first, then the wakeup releases A.
    put(4'd1, 6'd3, 1'b0, 6'd4, 1'b1, 6'd10); tick();
    put(4'd2, 6'd5, 1'b1, 6'd6, 1'b1, 6'd11); tick();
    put(4'd3, 6'd7, 1'b1, 6'd8, 1'b1, 6'd12); tick();
    #1 chk("first_B", dst_out, 11);
    issue = 1'b1; tick();
    #1 chk("then_C", dst_out, 12);
    issue = 1'b1; tick();
    #1 chk("A_blocked", issue_ready, 0);
    cdb_valid = 2'b01; cdb_tag = 12'd3; tick();
    #1 chk("A_woken", dst_out, 10);
    issue = 1'b1; tick();

    // Refill freed low slots; order must still follow dispatch.
    for (int i = 0; i < N; i++) begin put(4'd0, 6'd1, 1'b1, 6'd2, 1'b1, 6'(i)); tick(); end
    issue = 1'b1; tick();
    issue = 1'b1; tick();
    put(4'd0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd8); tick();
    put(4'd0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd9); tick();
    for (int i = 2; i < 10; i++) begin
      #1 chk("refill_order", dst_out, i);
      issue = 1'b1; tick();
    end

    // Same-cycle broadcast of the loaded operand tag.
    put(4'd5, 6'd1, 1'b1, 6'd9, 1'b0, 6'd20);
    cdb_valid = 2'b10; cdb_tag = {6'd9, 6'd0}; tick();
`ifdef IQ_CDB_BYPASS_EN
    #1 chk("bypass_ready", issue_ready, 1);
`else
    #1 chk("bypass_ready", issue_ready, 0);
`endif
    for (int i = 0; i < 3; i++) tick();
    flush = 1'b1; tick();

    // Flush wins over a simultaneous load.
    for (int i = 0; i < 5; i++) begin put(4'd0, 6'd1, 1'b1, 6'd2, 1'b1, 6'(i)); tick(); end
    flush = 1'b1; put(4'd0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd33); tick();
    #1 chk("flush_count", count, 0);
    chk("flush_empty", is_empty, 1);
    chk("flush_ready", issue_ready, 0);

    // Asynchronous reset in the middle of a cycle with a load pending.
    for (int i = 0; i < 4; i++) begin put(4'd0, 6'd1, 1'b1, 6'd2, 1'b1, 6'(i)); tick(); end
    put(4'd0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd44); issue = 1'b1;
    #2 reset_n = 1'b0;
    #1 q.delete();
    check_outputs();
    chk("async_count", count, 0);
    @(negedge clk);
    load = 1'b0; issue = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Random traffic with a narrow tag space so wakeups hit often.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(1, 0) == 1)
        put(4'($urandom), 6'($urandom_range(7, 0)), 1'($urandom), 6'($urandom_range(7, 0)), 1'($urandom), 6'($urandom));
      issue = 1'($urandom);
      cdb_valid = 2'($urandom);
      cdb_tag = {6'($urandom_range(7, 0)), 6'($urandom_range(7, 0))};
      flush = ($urandom_range(39, 0) == 0);
      tick();
    end
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
